// File: rtl/reg_alu_pipe.sv
// Two-stage register file + 8-op ALU datapath with a valid/ready issue port.
// Optional macro REG_ALU_BYPASS_EN: forward the EX write-back value instead of stalling on a RAW hazard.
module reg_alu_pipe #(
  parameter  int unsigned WIDTH = 16,
  parameter  int unsigned NREGS = 8,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sel,
  input  logic             wr,
  input  logic [2:0]       op,
  input  logic [AW-1:0]    rd_addr_a,
  input  logic [AW-1:0]    rd_addr_b,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] d_out_a,
  output logic [WIDTH-1:0] d_out_b,
  output logic [WIDTH-1:0] res,
  output logic             res_valid,
  output logic             cout,
  output logic             zero
);

  localparam int unsigned SW = WIDTH + 1;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_NOT = 3'd5;
  localparam logic [2:0] OP_SHL = 3'd6;
  localparam logic [2:0] OP_ADC = 3'd7;

  logic [WIDTH-1:0] r_regs [NREGS];
  logic             r_ex_valid;
  logic             r_ex_sel;
  logic             r_ex_wr;
  logic [2:0]       r_ex_op;
  logic [AW-1:0]    r_ex_waddr;
  logic [WIDTH-1:0] r_ex_din;
  logic [WIDTH-1:0] r_ex_a;
  logic [WIDTH-1:0] r_ex_b;
  logic [WIDTH-1:0] r_res;
  logic             r_res_valid;
  logic             r_cout;
  logic             r_zero;

  logic [SW-1:0]    w_sum;
  logic [WIDTH-1:0] w_alu;
  logic             w_alu_c;
  logic             w_c_upd;
  logic [WIDTH-1:0] w_wb;
  logic             w_haz_a;
  logic             w_haz_b;
  logic [WIDTH-1:0] w_op_a;
  logic [WIDTH-1:0] w_op_b;
  logic             w_accept;

  // ALU: every op produces a WIDTH+1 result whose MSB is the candidate carry
  always_comb begin
    w_sum   = '0;
    w_c_upd = 1'b0;
    case (r_ex_op)
      OP_ADD: begin
        w_sum   = {1'b0, r_ex_a} + {1'b0, r_ex_b};
        w_c_upd = 1'b1;
      end
      OP_SUB: begin
        w_sum   = {1'b0, r_ex_a} + {1'b0, ~r_ex_b} + SW'(1);
        w_c_upd = 1'b1;
      end
      OP_AND: w_sum = {1'b0, r_ex_a & r_ex_b};
      OP_OR:  w_sum = {1'b0, r_ex_a | r_ex_b};
      OP_XOR: w_sum = {1'b0, r_ex_a ^ r_ex_b};
      OP_NOT: w_sum = {1'b0, ~r_ex_a};
      OP_SHL: begin
        w_sum   = {r_ex_a, 1'b0};
        w_c_upd = 1'b1;
      end
      OP_ADC: begin
        w_sum   = {1'b0, r_ex_a} + {1'b0, r_ex_b} + SW'(r_cout);
        w_c_upd = 1'b1;
      end
      default: w_sum = '0;
    endcase
  end

  assign w_alu    = w_sum[WIDTH-1:0];
  assign w_alu_c  = w_sum[WIDTH];
  assign w_wb     = r_ex_sel ? w_alu : r_ex_din;

  assign w_haz_a  = r_ex_valid & r_ex_wr & (rd_addr_a == r_ex_waddr);
  assign w_haz_b  = r_ex_valid & r_ex_wr & (rd_addr_b == r_ex_waddr);

`ifdef REG_ALU_BYPASS_EN
  assign w_op_a   = w_haz_a ? w_wb : r_regs[rd_addr_a];
  assign w_op_b   = w_haz_b ? w_wb : r_regs[rd_addr_b];
  assign in_ready = reset;
`else
  assign w_op_a   = r_regs[rd_addr_a];
  assign w_op_b   = r_regs[rd_addr_b];
  assign in_ready = reset & ~(w_haz_a | w_haz_b);
`endif

  assign w_accept = in_valid & in_ready;

  // Register file write-back
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_regs <= '{default: '0};
    end else if (r_ex_valid && r_ex_wr) begin
      r_regs[r_ex_waddr] <= w_wb;
    end
  end

  // RD->EX capture, retire, result and flag registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ex_valid  <= 1'b0;
      r_ex_sel    <= 1'b0;
      r_ex_wr     <= 1'b0;
      r_ex_op     <= '0;
      r_ex_waddr  <= '0;
      r_ex_din    <= '0;
      r_ex_a      <= '0;
      r_ex_b      <= '0;
      r_res       <= '0;
      r_res_valid <= 1'b0;
      r_cout      <= 1'b0;
      r_zero      <= 1'b0;
    end else begin
      r_ex_valid  <= w_accept;
      r_res_valid <= r_ex_valid;
      if (w_accept) begin
        r_ex_sel   <= sel;
        r_ex_wr    <= wr;
        r_ex_op    <= op;
        r_ex_waddr <= wr_addr;
        r_ex_din   <= d_in;
        r_ex_a     <= w_op_a;
        r_ex_b     <= w_op_b;
      end
      if (r_ex_valid) begin
        r_res <= w_wb;
        if (r_ex_sel) begin
          r_zero <= (w_alu == '0);
          if (w_c_upd) r_cout <= w_alu_c;
        end
      end
    end
  end

  assign d_out_a   = r_ex_a;
  assign d_out_b   = r_ex_b;
  assign res       = r_res;
  assign res_valid = r_res_valid;
  assign cout      = r_cout;
  assign zero      = r_zero;

endmodule
